// File: rtl/aes_pkg.sv
// Shared AES SubBytes scheduling types: column count, lane grant
// encoding and the state-requester FSM encoding.
package aes_pkg;

    localparam int NUM_COLS = 4;
    localparam int COL_W    = $clog2(NUM_COLS);

    typedef logic [COL_W-1:0] col_t;

    localparam col_t LAST_COL = col_t'(NUM_COLS - 1);

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_ST   = 2'b01,
        GRANT_KW   = 2'b10
    } grant_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } st_state_e;

    // Column 0 is the most significant word of the state.
    function automatic logic [31:0] get_col(
        input logic [127:0] s,
        input col_t         c
    );
        logic [31:0] w;
        w = '0;
        unique case (c)
            2'd0:    w = s[127:96];
            2'd1:    w = s[95:64];
            2'd2:    w = s[63:32];
            default: w = s[31:0];
        endcase
        return w;
    endfunction

    function automatic logic [127:0] put_col(
        input logic [127:0] s,
        input col_t         c,
        input logic [31:0]  w
    );
        logic [127:0] r;
        r = s;
        unique case (c)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/subbytes_sched_if.sv
// Request/result bundle between the AES requesters and subbytes_sched.
// master: requester side (valid/data out); slave: the scheduler.
interface subbytes_sched_if;

    logic         st_valid;
    logic         st_ready;
    logic [127:0] st_data;
    logic [127:0] st_out;
    logic         st_done;

    logic         kw_valid;
    logic         kw_ready;
    logic [31:0]  kw_data;
    logic [31:0]  kw_out;
    logic         kw_done;

    modport master (
        output st_valid, st_data,
        output kw_valid, kw_data,
        input  st_ready, st_out, st_done,
        input  kw_ready, kw_out, kw_done
    );

    modport slave (
        input  st_valid, st_data,
        input  kw_valid, kw_data,
        output st_ready, st_out, st_done,
        output kw_ready, kw_out, kw_done
    );

endinterface

// File: rtl/sbox.sv
// AES forward S-box, one byte, combinational table lookup.
// Ports: byte_i (8b in), byte_o (8b substituted out).
module sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    // Ascending index so SBOX[x] reads the table in natural order.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byte_o = SBOX[byte_i];

endmodule

// File: rtl/sbox_word.sv
// One 32-bit SubBytes lane: four byte S-boxes side by side.
// Ports: word_i (32b in), word_o (32b substituted out).
module sbox_word (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        sbox u_sbox (
            .byte_i (word_i[8*i +: 8]),
            .byte_o (word_o[8*i +: 8])
        );
    end

endmodule

// File: rtl/subbytes_sched.sv
// Time-shared SubBytes lane arbitrated between the round datapath
// (128-bit state, four column beats) and the key expander (SubWord).
// Ports: clk, rst (sync, active-high), bus (subbytes_sched_if.slave).
// Param: FAIR=1 alternates under contention, FAIR=0 favours kw.
module subbytes_sched
    import aes_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input logic             clk,
    input logic             rst,
    subbytes_sched_if.slave bus
);

    st_state_e    state_q, state_d;
    col_t         col_q, col_d;
    logic [127:0] st_buf_q, st_buf_d;
    logic [127:0] st_out_q, st_out_d;
    logic         st_done_q, st_done_d;

    logic         kw_vld_q, kw_vld_d;
    logic [31:0]  kw_buf_q, kw_buf_d;
    logic [31:0]  kw_out_q, kw_out_d;
    logic         kw_done_q, kw_done_d;

    grant_e       prev_q, prev_d;
    grant_e       grant;

    logic         st_pend;
    logic         kw_pend;
    logic         kw_acc;
    logic [31:0]  lane_in;
    logic [31:0]  lane_out;

    // Ready depends on registered buffer state only.
    assign st_pend = (state_q == S_RUN);
    assign kw_pend = kw_vld_q;
    assign kw_acc  = bus.kw_valid && !kw_vld_q;

    assign bus.st_ready = !st_pend;
    assign bus.kw_ready = !kw_pend;
    assign bus.st_out   = st_out_q;
    assign bus.st_done  = st_done_q;
    assign bus.kw_out   = kw_out_q;
    assign bus.kw_done  = kw_done_q;

    // Arbiter: prev_q only advances on a real grant, so an idle gap
    // does not change whose turn it is.
    always_comb begin
        grant = GRANT_NONE;
        unique case ({kw_pend, st_pend})
            2'b10: grant = GRANT_KW;
            2'b01: grant = GRANT_ST;
            2'b11: begin
                if (FAIR) begin
                    grant = (prev_q == GRANT_ST) ? GRANT_KW : GRANT_ST;
                end else begin
                    grant = GRANT_KW;
                end
            end
            default: grant = GRANT_NONE;
        endcase
    end

    assign prev_d = (grant == GRANT_NONE) ? prev_q : grant;

    assign lane_in = (grant == GRANT_KW) ? kw_buf_q
                                         : get_col(st_buf_q, col_q);

    sbox_word u_lane (
        .word_i (lane_in),
        .word_o (lane_out)
    );

    // State requester FSM and column sequencing.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        st_buf_d  = st_buf_q;
        st_out_d  = st_out_q;
        st_done_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.st_valid) begin
                    st_buf_d = bus.st_data;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (grant == GRANT_ST) begin
                    st_out_d = put_col(st_out_q, col_q, lane_out);
                    if (col_q == LAST_COL) begin
                        col_d     = '0;
                        state_d   = S_IDLE;
                        st_done_d = 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Key-word buffer: a grant and an accept never coincide because
    // a grant needs the buffer full and an accept needs it empty.
    always_comb begin
        kw_vld_d  = kw_vld_q;
        kw_buf_d  = kw_buf_q;
        kw_out_d  = kw_out_q;
        kw_done_d = 1'b0;
        if (grant == GRANT_KW) begin
            kw_out_d  = lane_out;
            kw_vld_d  = 1'b0;
            kw_done_d = 1'b1;
        end
        if (kw_acc) begin
            kw_buf_d = bus.kw_data;
            kw_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            st_buf_q  <= '0;
            st_out_q  <= '0;
            st_done_q <= 1'b0;
            kw_vld_q  <= 1'b0;
            kw_buf_q  <= '0;
            kw_out_q  <= '0;
            kw_done_q <= 1'b0;
            prev_q    <= GRANT_KW;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            st_buf_q  <= st_buf_d;
            st_out_q  <= st_out_d;
            st_done_q <= st_done_d;
            kw_vld_q  <= kw_vld_d;
            kw_buf_q  <= kw_buf_d;
            kw_out_q  <= kw_out_d;
            kw_done_q <= kw_done_d;
            prev_q    <= prev_d;
        end
    end

endmodule

// File: tb/tb_subbytes_sched.sv
// Scoreboard bench for subbytes_sched: one fair and one strict
// instance; expected results come from a GF(2^8) S-box model.
module tb_subbytes_sched;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [127:0] st_exp_q[$];
    logic [31:0]  kw_exp_q[$];

    subbytes_sched_if bf();
    subbytes_sched_if bs();

    subbytes_sched #(.FAIR(1'b1)) dut_f (
        .clk (clk),
        .rst (rst),
        .bus (bf.slave)
    );

    subbytes_sched #(.FAIR(1'b0)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bs.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] a);
        logic [7:0] v;
        logic [7:0] s;
        v = '0;
        for (int b = 1; b < 256; b++) begin
            if (a != 0 && gmul(a, 8'(b)) == 8'h01) v = 8'(b);
        end
        s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
              ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = sb(w[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sb(s[8*i +: 8]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bf.st_ready !== 1'b1 || bs.st_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_st_ready got %b/%b want 1", bf.st_ready, bs.st_ready);
        end
        checks++;
        if (bf.kw_ready !== 1'b1 || bs.kw_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_kw_ready got %b/%b want 1", bf.kw_ready, bs.kw_ready);
        end
        checks++;
        if (bf.st_done !== 1'b0 || bf.kw_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b/%b want 0", bf.st_done, bf.kw_done);
        end
        checks++;
        if (bf.st_out !== 128'h0 || bf.kw_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_out got %h/%h want 0", bf.st_out, bf.kw_out);
        end
    endtask

    task automatic test_state_uncontended();
        logic [127:0] got;
        int done_at;
        int pulses;
        done_at = -1;
        pulses  = 0;
        bf.st_valid = 1'b1;
        bf.st_data  = 128'h0;
        tick();
        st_exp_q.push_back(128'h63636363_63636363_63636363_63636363);
        bf.st_valid = 1'b0;
        checks++;
        if (bf.st_ready !== 1'b0) begin
            errors++;
            $display("FAIL st_busy_ready got %b want 0", bf.st_ready);
        end
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 4) begin
                checks++;
                if (bf.st_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL st_ready_after_e4 got %b want 1", bf.st_ready);
                end
            end
            if (bf.st_done === 1'b1) begin
                pulses++;
                if (done_at < 0) done_at = k;
                got = st_exp_q.size() > 0 ? st_exp_q.pop_front() : 128'hx;
                checks++;
                if (bf.st_out !== got) begin
                    errors++;
                    $display("FAIL st_zero_value got %h want %h", bf.st_out, got);
                end
            end
        end
        checks++;
        if (done_at != 4 || pulses != 1) begin
            errors++;
            $display("FAIL st_zero_timing got at=%0d n=%0d want at=4 n=1", done_at, pulses);
        end
    endtask

    task automatic test_kw_uncontended();
        logic [31:0] got;
        int done_at;
        done_at = -1;
        bf.kw_valid = 1'b1;
        bf.kw_data  = 32'h00000153;
        tick();
        kw_exp_q.push_back(32'h63637ced);
        bf.kw_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (bf.kw_done === 1'b1) begin
                if (done_at < 0) done_at = k;
                got = kw_exp_q.size() > 0 ? kw_exp_q.pop_front() : 32'hx;
                checks++;
                if (bf.kw_out !== got) begin
                    errors++;
                    $display("FAIL kw_value got %h want %h", bf.kw_out, got);
                end
            end
        end
        checks++;
        if (done_at != 1) begin
            errors++;
            $display("FAIL kw_timing got %0d want 1", done_at);
        end
    endtask

    task automatic test_contention_fair();
        logic [127:0] sgot;
        logic [31:0]  kgot;
        int st_at;
        int kw_at;
        st_at = -1;
        kw_at = -1;
        pulse_reset();
        bf.st_valid = 1'b1;
        bf.st_data  = 128'h00112233_44556677_8899aabb_ccddeeff;
        bf.kw_valid = 1'b1;
        bf.kw_data  = 32'h53535353;
        tick();
        st_exp_q.push_back(128'h638293c3_1bfc33f5_c4eeacea_4bc12816);
        kw_exp_q.push_back(32'hedededed);
        bf.st_valid = 1'b0;
        bf.kw_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                checks++;
                if (bf.st_out[127:96] !== 32'h638293c3 || bf.kw_done !== 1'b0) begin
                    errors++;
                    $display("FAIL fair_beat1 got %h/%b want 638293c3/0", bf.st_out[127:96], bf.kw_done);
                end
            end
            if (k == 2) begin
                checks++;
                if (bf.st_out[95:64] !== 32'h0) begin
                    errors++;
                    $display("FAIL fair_beat2_col1 got %h want 0", bf.st_out[95:64]);
                end
            end
            if (bf.kw_done === 1'b1) begin
                if (kw_at < 0) kw_at = k;
                kgot = kw_exp_q.size() > 0 ? kw_exp_q.pop_front() : 32'hx;
                checks++;
                if (bf.kw_out !== kgot) begin
                    errors++;
                    $display("FAIL fair_kw_value got %h want %h", bf.kw_out, kgot);
                end
            end
            if (bf.st_done === 1'b1) begin
                if (st_at < 0) st_at = k;
                sgot = st_exp_q.size() > 0 ? st_exp_q.pop_front() : 128'hx;
                checks++;
                if (bf.st_out !== sgot) begin
                    errors++;
                    $display("FAIL fair_st_value got %h want %h", bf.st_out, sgot);
                end
            end
        end
        checks++;
        if (kw_at != 2 || st_at != 5) begin
            errors++;
            $display("FAIL fair_timing got kw=%0d st=%0d want kw=2 st=5", kw_at, st_at);
        end
    endtask

    task automatic test_strict_priority();
        logic [127:0] sgot;
        logic [31:0]  kgot;
        logic sa;
        logic ka;
        logic st_fin;
        int st_at;
        int kw_before;
        st_fin    = 1'b0;
        st_at     = -1;
        kw_before = 0;
        pulse_reset();
        bs.st_valid = 1'b1;
        bs.st_data  = {$urandom, $urandom, $urandom, $urandom};
        bs.kw_valid = 1'b1;
        bs.kw_data  = $urandom;
        for (int i = 0; i < 40; i++) begin
            sa = bs.st_valid && bs.st_ready;
            ka = bs.kw_valid && bs.kw_ready;
            tick();
            if (sa) begin
                st_exp_q.push_back(sub_state(bs.st_data));
                bs.st_valid = 1'b0;
            end
            if (ka) begin
                kw_exp_q.push_back(sub_word(bs.kw_data));
                if (st_fin) bs.kw_valid = 1'b0;
                else bs.kw_data = $urandom;
            end
            if (bs.kw_done === 1'b1) begin
                if (!st_fin) kw_before++;
                kgot = kw_exp_q.size() > 0 ? kw_exp_q.pop_front() : 32'hx;
                checks++;
                if (bs.kw_out !== kgot) begin
                    errors++;
                    $display("FAIL strict_kw_value got %h want %h", bs.kw_out, kgot);
                end
            end
            if (bs.st_done === 1'b1) begin
                st_fin = 1'b1;
                st_at  = i;
                sgot = st_exp_q.size() > 0 ? st_exp_q.pop_front() : 128'hx;
                checks++;
                if (bs.st_out !== sgot) begin
                    errors++;
                    $display("FAIL strict_st_value got %h want %h", bs.st_out, sgot);
                end
            end
            if (st_fin && !bs.kw_valid && kw_exp_q.size() == 0) break;
        end
        bs.kw_valid = 1'b0;
        checks++;
        if (st_at != 8 || kw_before != 4) begin
            errors++;
            $display("FAIL strict_timing got st=%0d kw=%0d want st=8 kw=4", st_at, kw_before);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d2;
        logic [127:0] sgot;
        int pulses;
        int done_at;
        pulses  = 0;
        done_at = -1;
        pulse_reset();
        bf.st_valid = 1'b1;
        bf.st_data  = {$urandom, $urandom, $urandom, $urandom};
        tick();
        bf.st_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bf.st_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bf.st_out !== 128'h0) begin
            errors++;
            $display("FAIL abort_quiet got n=%0d out=%h want 0/0", pulses, bf.st_out);
        end
        checks++;
        if (bf.st_ready !== 1'b1 || bf.kw_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready got %b/%b want 1/1", bf.st_ready, bf.kw_ready);
        end
        d2 = {$urandom, $urandom, $urandom, $urandom};
        bf.st_valid = 1'b1;
        bf.st_data  = d2;
        tick();
        st_exp_q.push_back(sub_state(d2));
        bf.st_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bf.st_done === 1'b1) begin
                if (done_at < 0) done_at = k;
                sgot = st_exp_q.size() > 0 ? st_exp_q.pop_front() : 128'hx;
                checks++;
                if (bf.st_out !== sgot) begin
                    errors++;
                    $display("FAIL abort_next_value got %h want %h", bf.st_out, sgot);
                end
            end
        end
        checks++;
        if (done_at != 4) begin
            errors++;
            $display("FAIL abort_next_timing got %0d want 4", done_at);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] b_data;
        logic [127:0] sgot;
        logic sa;
        int acc_at[2];
        int done_at[2];
        int n_acc;
        int n_done;
        n_acc  = 0;
        n_done = 0;
        acc_at  = '{-1, -1};
        done_at = '{-1, -1};
        pulse_reset();
        b_data = {$urandom, $urandom, $urandom, $urandom};
        bf.st_valid = 1'b1;
        bf.st_data  = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 20; i++) begin
            sa = bf.st_valid && bf.st_ready;
            tick();
            if (sa) begin
                st_exp_q.push_back(sub_state(bf.st_data));
                if (n_acc < 2) acc_at[n_acc] = i;
                n_acc++;
                if (n_acc == 1) bf.st_data = b_data;
                else bf.st_valid = 1'b0;
            end
            if (bf.st_done === 1'b1) begin
                if (n_done < 2) done_at[n_done] = i;
                n_done++;
                sgot = st_exp_q.size() > 0 ? st_exp_q.pop_front() : 128'hx;
                checks++;
                if (bf.st_out !== sgot) begin
                    errors++;
                    $display("FAIL b2b_value got %h want %h", bf.st_out, sgot);
                end
            end
            if (n_done >= 2) break;
        end
        bf.st_valid = 1'b0;
        checks++;
        if (acc_at[0] != 0 || acc_at[1] != 5) begin
            errors++;
            $display("FAIL b2b_accept got %0d,%0d want 0,5", acc_at[0], acc_at[1]);
        end
        checks++;
        if (done_at[0] != 4 || done_at[1] != 9 || n_done != 2) begin
            errors++;
            $display("FAIL b2b_done got %0d,%0d n=%0d want 4,9 n=2", done_at[0], done_at[1], n_done);
        end
    endtask

    initial begin
        rst = 1'b1;
        bf.st_valid = 1'b0;
        bf.st_data  = '0;
        bf.kw_valid = 1'b0;
        bf.kw_data  = '0;
        bs.st_valid = 1'b0;
        bs.st_data  = '0;
        bs.kw_valid = 1'b0;
        bs.kw_data  = '0;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_state_uncontended();
        test_kw_uncontended();
        test_contention_fair();
        test_strict_priority();
        test_reset_mid();
        test_back_to_back();
        checks++;
        if (st_exp_q.size() != 0 || kw_exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got st=%0d kw=%0d want 0/0", st_exp_q.size(), kw_exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
